// File: rtl/typing_engine_if.sv
// typing_engine_if: bundles the keyboard/renderer-facing signals of the
// typing race core.
//   master : keyboard decoder + renderer side (drives keys and the head-word
//            lookup, reads every live game value)
//   slave  : typing_engine side
// Signals:
//   key_valid / key_code     one-cycle key strobe and decoded key
//   target_word / target_len dictionary lookup of rd[7:0], combinational
//   type_buf                 typed characters, char k at [5k+:5]
//                            ("type" is a reserved word, hence the suffix)
//   tot / correct            buffer length / matching-prefix length
//   rd                       word-id queue, head at [7:0]
//   times, wpm, acc, percent elapsed tenths, speed, accuracy, progress
//   game_done                high while the race is finished
interface typing_engine_if;
  logic        key_valid;
  logic [4:0]  key_code;
  logic [74:0] target_word;
  logic [4:0]  target_len;
  logic [74:0] type_buf;
  logic [4:0]  tot;
  logic [4:0]  correct;
  logic [47:0] rd;
  logic [14:0] times;
  logic [9:0]  wpm;
  logic [9:0]  acc;
  logic [9:0]  percent;
  logic        game_done;

  modport master (
    output key_valid, key_code, target_word, target_len,
    input  type_buf, tot, correct, rd, times, wpm, acc, percent, game_done
  );

  modport slave (
    input  key_valid, key_code, target_word, target_len,
    output type_buf, tot, correct, rd, times, wpm, acc, percent, game_done
  );
endinterface

// File: rtl/typing_engine.sv
// typing_engine: game-logic core of the typing race. Consumes decoded
// keystrokes, keeps the typed buffer and prefix match against the head word,
// manages the word-id queue, counts time in 0.1 s ticks and derives WPM,
// accuracy and progress with one shared restoring divider.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  typing_engine_if.slave (keys and head word in, game values out)
// Parameters:
//   TICK_CYCLES  clk cycles per 0.1 s tick
//   GOAL_WORDS   words needed to finish (1..63)
//   DICT_WORDS   dictionary size, power of two <= 256
module typing_engine #(
  parameter int unsigned TICK_CYCLES = 10_000_000,
  parameter int unsigned GOAL_WORDS  = 20,
  parameter int unsigned DICT_WORDS  = 64
) (
  input  logic           clk,
  input  logic           rst,
  typing_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  state_t state, state_next;

  logic [15:0] lfsr;
  logic [2:0]  fill_cnt;
  logic [74:0] type_buf;
  logic [4:0]  tot, correct;
  logic [47:0] rd;
  logic [14:0] times;
  logic [9:0]  wpm, acc, percent;
  logic [15:0] keystrokes, good;
  logic [9:0]  chars_done;
  logic [5:0]  words_done;
  logic [31:0] tick_cnt;

  logic        pend;
  logic        div_busy, div_load;
  logic [1:0]  div_sel;
  logic [4:0]  div_cnt;
  logic [23:0] div_q;
  logic [15:0] div_rem, div_den;
  logic [15:0] snap_good, snap_keys;
  logic [9:0]  snap_chars;
  logic [14:0] snap_times;
  logic [5:0]  snap_words;

  logic        is_enter, is_letter, is_space, is_bksp;
  logic        accept, last_word, force_pass, tick_hit, div_start, restart;
  logic [4:0]  tgt_char;
  logic [7:0]  new_id;
  logic        lfsr_fb;
  logic [14:0] times_inc;
  logic [15:0] keys_inc, good_inc;
  logic [23:0] op_num;
  logic [15:0] op_den;
  logic [16:0] shifted;
  logic        ge;
  logic [15:0] rem_next;
  logic [23:0] q_next;

  always_comb begin
    is_enter  = bus.key_valid && (bus.key_code == 5'd29);
    is_letter = bus.key_valid && (bus.key_code >= 5'd1) && (bus.key_code <= 5'd26);
    is_space  = bus.key_valid && (bus.key_code == 5'd27);
    is_bksp   = bus.key_valid && (bus.key_code == 5'd28);

    tgt_char = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      if (tot == 5'(i)) tgt_char = bus.target_word[5*i +: 5];
    end

    accept     = (state == RUN) && is_space && (tot == bus.target_len) && (correct == tot);
    last_word  = (words_done + 6'd1) == 6'(GOAL_WORDS);
    force_pass = accept && last_word;
    tick_hit   = (state == RUN) && (tick_cnt == 32'(TICK_CYCLES - 1));
    div_start  = !div_busy && (tick_hit || pend);
    restart    = is_enter && ((state == IDLE) || (state == DONE));

    lfsr_fb   = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    new_id    = lfsr[7:0] & 8'(DICT_WORDS - 1);
    times_inc = (times == '1) ? times : times + 15'd1;
    keys_inc  = (keystrokes == '1) ? keystrokes : keystrokes + 16'd1;
    good_inc  = (good == '1) ? good : good + 16'd1;
  end

  // Operand select for the three divisions of a stats pass.
  always_comb begin
    op_num = '0;
    op_den = '0;
    case (div_sel)
      2'd0: begin
        op_num = 24'(snap_good) * 24'd100;
        op_den = snap_keys;
      end
      2'd1: begin
        op_num = 24'(snap_chars) * 24'd120;
        op_den = {1'b0, snap_times};
      end
      default: begin
        op_num = 24'(snap_words) * 24'd100;
        op_den = 16'(GOAL_WORDS);
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted  = {div_rem, div_q[23]};
    ge       = shifted >= {1'b0, div_den};
    rem_next = ge ? 16'(shifted - {1'b0, div_den}) : shifted[15:0];
    q_next   = {div_q[22:0], ge};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (is_enter) state_next = FILL;
      FILL:    if (fill_cnt == 3'd5) state_next = RUN;
      RUN:     if (force_pass) state_next = DONE;
      DONE:    if (is_enter) state_next = FILL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= 16'hACE1;
      fill_cnt   <= '0;
      type_buf   <= '0;
      tot        <= '0;
      correct    <= '0;
      rd         <= '0;
      times      <= '0;
      wpm        <= '0;
      acc        <= '0;
      percent    <= '0;
      keystrokes <= '0;
      good       <= '0;
      chars_done <= '0;
      words_done <= '0;
      tick_cnt   <= '0;
      pend       <= 1'b0;
      div_busy   <= 1'b0;
      div_load   <= 1'b0;
      div_sel    <= '0;
      div_cnt    <= '0;
      div_q      <= '0;
      div_rem    <= '0;
      div_den    <= '0;
      snap_good  <= '0;
      snap_keys  <= '0;
      snap_chars <= '0;
      snap_times <= '0;
      snap_words <= '0;
    end else begin
      lfsr <= {lfsr_fb, lfsr[15:1]};

      if (restart) begin
        fill_cnt   <= '0;
        type_buf   <= '0;
        tot        <= '0;
        correct    <= '0;
        times      <= '0;
        wpm        <= '0;
        acc        <= '0;
        percent    <= '0;
        keystrokes <= '0;
        good       <= '0;
        chars_done <= '0;
        words_done <= '0;
        tick_cnt   <= '0;
        pend       <= 1'b0;
        div_busy   <= 1'b0;
        div_load   <= 1'b0;
      end else begin
        if (state == FILL) begin
          rd <= {new_id, rd[47:8]};
          if (fill_cnt == 3'd5) begin
            fill_cnt <= '0;
            acc      <= 10'd100;
          end else begin
            fill_cnt <= fill_cnt + 3'd1;
          end
        end

        if (state == RUN) begin
          if (tick_hit) begin
            tick_cnt <= '0;
            times    <= times_inc;
          end else begin
            tick_cnt <= tick_cnt + 32'd1;
          end

          if (is_letter && (tot < 5'd15)) begin
            for (int unsigned i = 0; i < 15; i++) begin
              if (tot == 5'(i)) type_buf[5*i +: 5] <= bus.key_code;
            end
            tot        <= tot + 5'd1;
            keystrokes <= keys_inc;
            if ((correct == tot) && (bus.key_code == tgt_char)) begin
              correct <= correct + 5'd1;
              good    <= good_inc;
            end
          end else if (is_bksp && (tot != 5'd0)) begin
            for (int unsigned i = 0; i < 15; i++) begin
              if (tot == 5'(i + 1)) type_buf[5*i +: 5] <= '0;
            end
            tot <= tot - 5'd1;
            if (correct == tot) correct <= correct - 5'd1;
          end else if (is_space) begin
            keystrokes <= keys_inc;
            if (accept) begin
              type_buf   <= '0;
              tot        <= '0;
              correct    <= '0;
              rd         <= {new_id, rd[47:8]};
              words_done <= words_done + 6'd1;
              chars_done <= chars_done + 10'(bus.target_len) + 10'd1;
              good       <= good_inc;
            end
          end
        end

        // A tick during a busy pass, or the race finishing, is held in pend.
        // The finishing pass is always deferred one cycle so its snapshot
        // includes the final accepted word.
        pend <= div_busy ? (pend | tick_hit | force_pass) : force_pass;

        if (div_start) begin
          // Registers still hold pre-key counts at this edge; times takes
          // the value this tick is producing.
          snap_good  <= good;
          snap_keys  <= keystrokes;
          snap_chars <= chars_done;
          snap_times <= tick_hit ? times_inc : times;
          snap_words <= words_done;
          div_busy   <= 1'b1;
          div_load   <= 1'b1;
          div_sel    <= '0;
        end else if (div_busy) begin
          if (div_load) begin
            div_q    <= op_num;
            div_den  <= op_den;
            div_rem  <= '0;
            div_cnt  <= 5'd24;
            div_load <= 1'b0;
          end else begin
            div_q   <= q_next;
            div_rem <= rem_next;
            div_cnt <= div_cnt - 5'd1;
            if (div_cnt == 5'd1) begin
              case (div_sel)
                2'd0:    acc <= (snap_keys == '0) ? 10'd100 : q_next[9:0];
                2'd1:    wpm <= (snap_times == '0) ? 10'd0 :
                                (q_next > 24'd999) ? 10'd999 : q_next[9:0];
                default: percent <= q_next[9:0];
              endcase
              if (div_sel == 2'd2) begin
                div_busy <= 1'b0;
              end else begin
                div_sel  <= div_sel + 2'd1;
                div_load <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign bus.type_buf  = type_buf;
  assign bus.tot       = tot;
  assign bus.correct   = correct;
  assign bus.rd        = rd;
  assign bus.times     = times;
  assign bus.wpm       = wpm;
  assign bus.acc       = acc;
  assign bus.percent   = percent;
  assign bus.game_done = (state == DONE);

endmodule

// File: tb/tb_typing_engine.sv
// tb_typing_engine: directed bench for typing_engine with hand-computed
// expectations. The head word is held at "cat" throughout; word ids are
// predicted from an independent model of the 16-bit LFSR clocked alongside
// the DUT.
module tb_typing_engine;
  localparam int unsigned TICK = 10;
  localparam int unsigned GOAL = 20;

  localparam logic [4:0] K_A     = 5'd1;
  localparam logic [4:0] K_B     = 5'd2;
  localparam logic [4:0] K_C     = 5'd3;
  localparam logic [4:0] K_Q     = 5'd17;
  localparam logic [4:0] K_T     = 5'd20;
  localparam logic [4:0] K_X     = 5'd24;
  localparam logic [4:0] K_SPACE = 5'd27;
  localparam logic [4:0] K_BKSP  = 5'd28;
  localparam logic [4:0] K_ENTER = 5'd29;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typing_engine_if bus();

  typing_engine #(
    .TICK_CYCLES(TICK),
    .GOAL_WORDS (GOAL),
    .DICT_WORDS (64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned run_start = 0;
  int unsigned tfinal = 0;
  int unsigned exp_wpm = 0;
  logic [15:0] m_lfsr;
  logic [15:0] pre_lfsr;
  logic [47:0] exp_rd;
  logic [74:0] exp_buf;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic logic [7:0] id_of(input logic [15:0] v);
    return v[7:0] & 8'h3f;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? 16'hACE1 : lstep(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] code);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    pre_lfsr      = m_lfsr;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
  endtask

  task automatic type_cat_word();
    press(K_C);
    press(K_A);
    press(K_T);
    press(K_SPACE);
    exp_rd = {id_of(pre_lfsr), exp_rd[47:8]};
  endtask

  task automatic start_game();
    logic [15:0] v;
    press(K_ENTER);
    v = m_lfsr;
    for (int k = 0; k < 6; k++) begin
      exp_rd = {id_of(v), exp_rd[47:8]};
      v = lstep(v);
    end
    step(6);
    run_start = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_type"}, bus.type_buf, 0);
    check_eq({tag, "_tot"}, bus.tot, 0);
    check_eq({tag, "_correct"}, bus.correct, 0);
    check_eq({tag, "_rd"}, bus.rd, 0);
    check_eq({tag, "_times"}, bus.times, 0);
    check_eq({tag, "_wpm"}, bus.wpm, 0);
    check_eq({tag, "_acc"}, bus.acc, 0);
    check_eq({tag, "_percent"}, bus.percent, 0);
    check_eq({tag, "_done"}, bus.game_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.key_valid   = 1'b0;
    bus.key_code    = '0;
    bus.target_word = 75'd20515;   // "cat": 3 | 1<<5 | 20<<10
    bus.target_len  = 5'd3;
    exp_rd          = '0;

    step(2);
    @(negedge clk) rst = 1'b0;
    step(1);
    check_all_zero("reset");

    // IDLE ignores everything but enter
    press(K_A);
    check_eq("idle_letter_tot", bus.tot, 0);
    press(K_SPACE);
    check_eq("idle_space_rd", bus.rd, 0);

    start_game();
    check_eq("fill_rd", bus.rd, exp_rd);
    check_eq("fill_acc", bus.acc, 100);
    check_eq("fill_done", bus.game_done, 0);
    step(9);
    check_eq("times_9", bus.times, 0);
    step(1);
    check_eq("times_10", bus.times, 1);

    press(K_C);
    press(K_A);
    press(K_T);
    check_eq("cat_type", bus.type_buf, 75'd20515);
    check_eq("cat_tot", bus.tot, 3);
    check_eq("cat_correct", bus.correct, 3);
    press(K_SPACE);
    exp_rd = {id_of(pre_lfsr), exp_rd[47:8]};
    check_eq("accept_rd", bus.rd, exp_rd);
    check_eq("accept_type", bus.type_buf, 0);
    check_eq("accept_tot", bus.tot, 0);
    check_eq("accept_correct", bus.correct, 0);
    step(200);
    check_eq("word1_acc", bus.acc, 100);
    check_eq("word1_percent", bus.percent, 5);

    // fill the buffer, then a 16th letter is dropped
    exp_buf = '0;
    for (int i = 0; i < 15; i++) begin
      press(K_B);
      exp_buf[5*i +: 5] = K_B;
    end
    press(K_Q);
    check_eq("full_tot", bus.tot, 15);
    check_eq("full_correct", bus.correct, 0);
    check_eq("full_type", bus.type_buf, exp_buf);
    for (int i = 0; i < 15; i++) press(K_BKSP);
    press(K_BKSP);
    check_eq("bksp0_tot", bus.tot, 0);
    check_eq("bksp0_type", bus.type_buf, 0);
    step(200);
    check_eq("full_acc", bus.acc, 21);            // 4*100/19
    check_eq("run_times", bus.times, (cyc - run_start) / TICK);

    for (int w = 0; w < 18; w++) type_cat_word();
    check_eq("word19_done", bus.game_done, 0);
    type_cat_word();
    tfinal = (cyc - run_start) / TICK;
    check_eq("word20_done", bus.game_done, 1);
    check_eq("word20_rd", bus.rd, exp_rd);
    press(K_A);
    check_eq("done_key_ignored", bus.tot, 0);
    step(250);
    exp_wpm = (tfinal == 0) ? 0 : 9600 / tfinal;  // 80 chars * 120
    if (exp_wpm > 999) exp_wpm = 999;
    check_eq("final_acc", bus.acc, 84);            // 80*100/95
    check_eq("final_percent", bus.percent, 100);
    check_eq("final_wpm", bus.wpm, exp_wpm);
    check_eq("final_times", bus.times, tfinal);
    check_eq("final_done", bus.game_done, 1);

    // restart from DONE
    start_game();
    check_eq("restart_rd", bus.rd, exp_rd);
    check_eq("restart_acc", bus.acc, 100);
    check_eq("restart_times", bus.times, 0);
    check_eq("restart_percent", bus.percent, 0);
    check_eq("restart_wpm", bus.wpm, 0);
    check_eq("restart_done", bus.game_done, 0);

    // errors: c x <space> <bksp> a  -> 2 good of 4 keystrokes
    press(K_C);
    press(K_X);
    check_eq("err_tot", bus.tot, 2);
    check_eq("err_correct", bus.correct, 1);
    press(K_SPACE);
    check_eq("err_space_tot", bus.tot, 2);
    check_eq("err_space_rd", bus.rd, exp_rd);
    press(K_BKSP);
    check_eq("err_bksp_tot", bus.tot, 1);
    check_eq("err_bksp_correct", bus.correct, 1);
    check_eq("err_bksp_type", bus.type_buf, 3);
    press(K_A);
    check_eq("err_fix_correct", bus.correct, 2);
    step(200);
    check_eq("err_acc", bus.acc, 50);
    check_eq("err_percent", bus.percent, 0);

    // reset mid-RUN with three letters typed
    press(K_T);
    check_eq("pre_rst_tot", bus.tot, 3);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrun_rst");
    @(negedge clk) rst = 1'b0;
    press(K_A);
    check_eq("post_rst_letter", bus.tot, 0);
    press(K_SPACE);
    check_eq("post_rst_space", bus.rd, 0);
    start_game();
    check_eq("post_rst_fill_rd", bus.rd, exp_rd);
    check_eq("post_rst_acc", bus.acc, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/typing_engine.md
# typing_engine

Game-logic core of the typing race: consumes decoded keystrokes and produces every live value the game screen renders. Outputs include the typed-character buffer, the prefix-match counts, the word-id queue, elapsed time, WPM, accuracy and race progress. Sits between the keyboard decoder and the game screen renderer. The renderer's dictionary lookup of the head word is fed back here as the comparison target.

## Interface
- TICK_CYCLES, 10_000_000: clk cycles per 0.1 s time tick (100 MHz clk).
- GOAL_WORDS, 20: words to finish the race (1..63).
- DICT_WORDS, 64: dictionary size, power of two ≤ 256.

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  5  1..26 = a..z, 27 = space, 28 = backspace, 29 = enter; others ignored.
- target_word  in  75  dictionary word for rd[7:0]: char k at [5k+:5], 0 = blank. Combinational, same cycle.
- target_len  in  5  length of target_word.
- type  out  75  typed buffer, char k at [5k+:5], unused slots 0.
- tot  out  5  chars in buffer (0..15).
- correct  out  5  length of the leading buffer prefix that matches target_word.
- rd  out  48  word-id queue, 6 × 8 bits, head at [7:0].
- times  out  15  elapsed tenths of seconds, saturates at 32767.
- wpm  out  10  words per minute, clamped to 999.
- acc  out  10  accuracy percent, 0..100.
- percent  out  10  progress percent, 0..100.
- game_done  out  1  high in DONE.

## Operation
- FSM IDLE → FILL → RUN → DONE.
  - IDLE: waits for enter, then goes to FILL.
  - FILL: 6 cycles. Each cycle shifts a new id into rd[47:40] (rd <= {id, rd[47:8]}), then goes to RUN and sets acc = 100.
  - RUN: accepts keys; stops at words_done == GOAL_WORDS and goes to DONE.
  - DONE: outputs frozen except the final stats pass. Enter restarts: counters cleared, then FILL.
- Enter in FILL or RUN is ignored. All keys in IDLE are ignored except enter.
- Id source: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, steps every cycle. id = lfsr[7:0] & (DICT_WORDS-1).
- Letter L in RUN, tot < 15:
  - type[5·tot+:5] <= L; tot+1; keystrokes+1.
  - If correct == tot and L == target_word char tot: correct+1, good+1.
  - tot == 15: ignored, nothing counted.
- Backspace: if tot > 0, clear slot tot-1 and tot-1. If correct == tot, also correct-1. Not a keystroke. Ignored at tot 0.
- Space, when tot == target_len and correct == tot (accept):
  - buffer cleared; tot, correct = 0.
  - rd shifts, new id in [47:40].
  - words_done+1; chars_done += target_len+1.
  - keystrokes+1, good+1.
- Space otherwise: keystrokes+1 only.
- keystrokes and good are 16-bit and saturate. chars_done is 10-bit.
- Invariant: correct ≤ tot ≤ 15.
- Stats pass: shares one restoring divider, 24-bit dividend, 16-bit divisor, 1 quotient bit per cycle. Three divisions run in sequence from a snapshot latched at the start of the pass:
  - acc = good·100 / keystrokes; 100 if keystrokes = 0.
  - wpm = chars_done·120 / times, clamped to 999; 0 if times = 0.
  - percent = words_done·100 / GOAL_WORDS.
- Each output updates when its own division completes.

## Timing
- Reset, effective at the next edge from any state: state IDLE; all outputs 0; counters 0; lfsr 16'hACE1; divider aborted; tick counter 0.
- Key effects are visible the cycle after key_valid. target_word is sampled that same cycle, so a key in the cycle after an accept compares against the new head word.
- Tick: the counter runs only in RUN. Every TICK_CYCLES it increments times and starts a stats pass.
- Stats pass: ~75 cycles total (3 × (24 + 1)). A tick while a pass is busy is recorded in a pending flag and runs after the current pass; a second pending tick merges into it.
- Entering DONE forces one final pass. game_done rises in the same cycle as DONE.
- Key and tick in the same cycle: both take effect; the pass snapshot holds the pre-key counts.
- Keys arriving during a pass are processed normally; the divider uses only its snapshot.

## Test plan
- Reset: assert rst mid-RUN with tot = 3 → next cycle all outputs 0, game_done 0, state IDLE, keys ignored until enter.
- Start: enter → after 6 cycles rd holds 6 LFSR-derived ids; acc = 100; times counts at TICK_CYCLES = 10.
- Word accept: target "cat" (3, 1, 20, len 3), type c, a, t → type = 20515, tot = 3, correct = 3. Then space → type = 0, tot = 0, rd shifted by 8 bits.
- Stats: after "cat ", times = 10 → next pass gives wpm = 48, acc = 100, percent = 5 (GOAL_WORDS = 20).
- Errors: target "cat", type c, x → tot = 2, correct = 1. Space rejected; backspace → tot = 1, correct = 1. Stats show acc = 50 (2 good of 4 keystrokes).
- Limits:
  - 15 letters then a 16th → tot stays 15.
  - Backspace at tot 0 → no change.
  - 20th accepted word → game_done = 1 and percent = 100 after the final pass.
  - Enter in DONE → restart.
